// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle instruction sequencer with memory-ready timeout
// Enables are gated by rst_n so an in-flight write is dropped the moment reset asserts.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op_class,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ext_sel,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [2:0] OPC_ALU_R  = 3'd0;
  localparam logic [2:0] OPC_ALU_I  = 3'd1;
  localparam logic [2:0] OPC_LOAD   = 3'd2;
  localparam logic [2:0] OPC_STORE  = 3'd3;
  localparam logic [2:0] OPC_BRANCH = 3'd4;
  localparam logic [2:0] OPC_JUMP   = 3'd5;
  localparam logic [2:0] OPC_CALL   = 3'd6;
  localparam logic [2:0] OPC_ILL    = 3'd7;

  // Last wait cycle that may still be rescued by mem_ready.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [2:0]       opc_q, opc_d;

  logic mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] pc_src_c, wb_sel_c;
  logic ext_sel_c, alu_src_b_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      opc_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    opc_d       = opc_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'd0;
    ext_sel_c   = 1'b0;
    alu_src_b_c = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = 2'd0;

    unique case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DECODE: begin
        opc_d   = op_class;
        state_d = (op_class == OPC_ILL) ? S_FAULT : S_EXEC;
      end

      S_EXEC: begin
        unique case (opc_q)
          OPC_ALU_R: state_d = S_WB;
          OPC_ALU_I: begin
            alu_src_b_c = 1'b1;
            state_d     = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b_c = 1'b1;
            state_d     = S_MEM;
          end
          OPC_BRANCH: begin
            pc_src_c   = 2'd1;
            pc_write_c = zero;
            state_d    = S_FETCH;
          end
          OPC_JUMP: begin
            ext_sel_c  = 1'b1;
            pc_src_c   = 2'd2;
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end
          OPC_CALL: begin
            ext_sel_c  = 1'b1;
            pc_src_c   = 2'd2;
            pc_write_c = 1'b1;
            state_d    = S_WB;
          end
          default: state_d = S_FAULT;
        endcase
      end

      S_MEM: begin
        mem_read_c  = (opc_q == OPC_LOAD);
        mem_write_c = (opc_q == OPC_STORE);
        if (mem_ready) begin
          state_d = (opc_q == OPC_LOAD) ? S_WB : S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        if (opc_q == OPC_LOAD)      wb_sel_c = 2'd1;
        else if (opc_q == OPC_CALL) wb_sel_c = 2'd2;
        state_d = S_FETCH;
      end

      default: state_d = S_FAULT;
    endcase
  end

  assign mem_read  = mem_read_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign pc_src    = pc_src_c;
  assign ext_sel   = ext_sel_c;
  assign alu_src_b = alu_src_b_c;
  assign wb_sel    = wb_sel_c;
  assign fault     = (state_q == S_FAULT);
  assign state_o   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - vector-table bench for the multicycle sequencer
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] op_class;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, ir_write, pc_write, ext_sel, alu_src_b, reg_write, fault;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_class(op_class), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .ext_sel(ext_sel), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .wb_sel(wb_sel), .fault(fault), .state_o(state_o)
  );

  // {state, mem_read, mem_write, ir_write, pc_write, pc_src, ext_sel, alu_src_b, reg_write, wb_sel, fault}
  typedef struct {
    logic        rst_n;
    logic [2:0]  opc;
    logic        zero;
    logic        rdy;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [14:0] e(input logic [2:0] st, input logic mr, input logic mw,
                                    input logic ir, input logic pw, input logic [1:0] ps,
                                    input logic es, input logic ab, input logic rw,
                                    input logic [1:0] ws, input logic f);
    return {st, mr, mw, ir, pw, ps, es, ab, rw, ws, f};
  endfunction

  function automatic logic [14:0] got_v();
    return {state_o, mem_read, mem_write, ir_write, pc_write, pc_src, ext_sel, alu_src_b,
            reg_write, wb_sel, fault};
  endfunction

  task automatic add(input logic r, input logic [2:0] opc, input logic z, input logic rdy,
                     input logic [14:0] ex);
    vec_t v;
    v.rst_n = r; v.opc = opc; v.zero = z; v.rdy = rdy; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [14:0] ex);
    logic [14:0] g;
    g = got_v();
    n_vec++;
    if (g !== ex) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, g, ex);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] opc, input logic z, input logic rdy,
                      input logic [14:0] ex, input string name);
    @(negedge clk);
    rst_n = r; op_class = opc; zero = z; mem_ready = rdy;
    #1;
    check(name, ex);
  endtask

  logic [14:0] X_FETCH_RDY, X_FETCH_WAIT, X_IDLE0, X_IDLE1, X_FAULT;

  initial begin
    rst_n = 1'b0; op_class = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    X_FETCH_RDY  = e(3'd0, 1, 0, 1, 1, 2'd0, 0, 0, 0, 2'd0, 0);
    X_FETCH_WAIT = e(3'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    X_IDLE0      = e(3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    X_IDLE1      = e(3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0);
    X_FAULT      = e(3'd7, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1);

    add(0, 0, 0, 0, X_IDLE0);
    // ALU_I
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 1, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, e(3'd2, 0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
    add(1, 0, 0, 1, e(3'd4, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0));
    // LOAD, three wait cycles in MEM
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 2, 0, 1, X_IDLE1);
    add(1, 0, 0, 0, e(3'd2, 0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, e(3'd3, 1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
    add(1, 0, 0, 1, e(3'd3, 1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
    add(1, 0, 0, 1, e(3'd4, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 0));
    // BRANCH not taken, then taken
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 4, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, e(3'd2, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0, 0));
    add(1, 0, 1, 1, X_FETCH_RDY);
    add(1, 4, 1, 1, X_IDLE1);
    add(1, 0, 1, 1, e(3'd2, 0, 0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 0));
    // CALL
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 6, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, e(3'd2, 0, 0, 0, 1, 2'd2, 1, 0, 0, 2'd0, 0));
    add(1, 0, 0, 1, e(3'd4, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 0));
    // JUMP
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 5, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, e(3'd2, 0, 0, 0, 1, 2'd2, 1, 0, 0, 2'd0, 0));
    // ALU_R
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 0, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, e(3'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
    add(1, 0, 0, 1, e(3'd4, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0));
    // STORE with one FETCH wait
    add(1, 0, 0, 0, X_FETCH_WAIT);
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 3, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, e(3'd2, 0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
    add(1, 0, 0, 1, e(3'd3, 0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
    // Illegal opcode, FAULT absorbs mem_ready
    add(1, 0, 0, 1, X_FETCH_RDY);
    add(1, 7, 0, 1, X_IDLE1);
    add(1, 0, 0, 1, X_FAULT);
    add(1, 0, 0, 1, X_FAULT);
    add(0, 0, 0, 1, X_IDLE0);

    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].opc, vecs[i].zero, vecs[i].rdy, vecs[i].exp,
           $sformatf("vec%0d", i));

    // FETCH timeout: 15 waiting cycles, then FAULT
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, X_FETCH_WAIT, $sformatf("tmo_wait%0d", i));
    step(1, 0, 0, 0, X_FAULT, "tmo_fault");
    step(0, 0, 0, 0, X_IDLE0, "tmo_reset");

    // Ready on the 15th cycle rescues the fetch
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, X_FETCH_WAIT, $sformatf("late_wait%0d", i));
    step(1, 0, 0, 1, X_FETCH_RDY, "late_ready");
    step(1, 3, 0, 0, X_IDLE1, "late_decode");

    // STORE: reset asserted mid-MEM drops mem_write without a clock edge
    step(1, 0, 0, 0, e(3'd2, 0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0), "st_exec");
    step(1, 0, 0, 0, e(3'd3, 0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0), "st_mem");
    #1 rst_n = 1'b0;
    #1 check("st_async_rst", X_IDLE0);
    step(1, 0, 0, 0, X_FETCH_WAIT, "st_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
